// File: rtl/dmem_responder.sv
// Data-side memory responder: word-addressed RAM with fixed read latency and a
// single posted-write buffer, answering the pipeline's dready_n/dbusy handshake.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WR_LAT     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] daddr,
    input  logic        doe,
    input  logic        dwe,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dbe,
    output logic [31:0] drdata,
    output logic        dready_n,
    output logic        dbusy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned IW    = DEPTH_LOG2;
    localparam logic [3:0]  RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0]  WR_CNT = 4'(WR_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wbe_q, wbe_d;
    logic          dready_n_q, dready_n_d;
    logic          dbusy_q, dbusy_d;
    logic [31:0]   drdata_q, drdata_d;
    logic          commit_c;
    logic [IW-1:0] req_idx;
    logic [IW-1:0] rd_idx;
    logic          unused_addr_bits;

    logic [31:0]   mem [DEPTH];

    assign req_idx          = daddr[IW+1:2];
    assign unused_addr_bits = ^{daddr[31:IW+2], daddr[1:0]};

    // Next-state, buffer capture and registered-output preparation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        wbe_d    = wbe_q;
        commit_c = 1'b0;
        rd_idx   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (doe) begin
                    // doe wins over dwe: a simultaneous write is dropped
                    state_d = READ;
                    cnt_d   = RD_CNT;
                    idx_d   = req_idx;
                    rd_idx  = req_idx;
                end else if (dwe) begin
                    state_d = DRAIN;
                    cnt_d   = WR_CNT;
                    idx_d   = req_idx;
                    wdata_d = dwdata;
                    wbe_d   = dbe;
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d  = IDLE;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobe is registered: assert it on the edge entering the cnt==0 read cycle
        dready_n_d = !((state_d == READ) && (cnt_d == 4'd0));
        dbusy_d    = (state_d == DRAIN);
        drdata_d   = dready_n_d ? drdata_q : mem[rd_idx];
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            wbe_q      <= 4'd0;
            dready_n_q <= 1'b1;
            dbusy_q    <= 1'b0;
            drdata_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wbe_q      <= wbe_d;
            dready_n_q <= dready_n_d;
            dbusy_q    <= dbusy_d;
            drdata_q   <= drdata_d;
        end
    end

    // RAM is never cleared; a reset edge suppresses the pending commit
    always_ff @(posedge clk) begin
        if (rst && commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign drdata   = drdata_q;
    assign dready_n = dready_n_q;
    assign dbusy    = dbusy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: timestamp-based reference model checked every cycle,
// plus directed transactions with hand-computed literal expectations.
module tb_dmem_responder;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 3;

    logic        clk;
    logic        rst;
    logic [31:0] daddr;
    logic        doe;
    logic        dwe;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic [31:0] drdata;
    logic        dready_n;
    logic        dbusy;

    int total = 0;
    int bad   = 0;

    dmem_responder #(
        .DEPTH_LOG2(10),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .daddr   (daddr),
        .doe     (doe),
        .dwe     (dwe),
        .dwdata  (dwdata),
        .dbe     (dbe),
        .drdata  (drdata),
        .dready_n(dready_n),
        .dbusy   (dbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: the responder is free from cycle free_at onward; every
    // accepted transaction is described by the cycles in which its effects appear.
    int          cyc        = 0;
    bit          chk_en     = 1'b0;
    int          free_at    = 0;
    int          rd_done_at = -1;
    int          busy_from  = -1;
    int          busy_to    = -1;
    int          commit_at  = -1;
    bit          wr_pend    = 1'b0;
    logic [9:0]  ridx_m     = '0;
    logic [9:0]  widx_m     = '0;
    logic [31:0] wdat_m     = '0;
    logic [3:0]  wbe_m      = '0;
    logic [31:0] mem_m [1024];
    bit          mem_v [1024];
    logic        exp_rdy_n  = 1'b1;
    logic        exp_busy   = 1'b0;
    logic [31:0] exp_rdata  = '0;
    bit          exp_rd_ok  = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                chk_en     = 1'b1;
                free_at    = cyc + 1;
                rd_done_at = -1;
                busy_from  = -1;
                busy_to    = -1;
                wr_pend    = 1'b0;
                exp_rdata  = 32'd0;
                exp_rd_ok  = 1'b1;
            end else begin
                if (wr_pend && cyc == commit_at) begin
                    for (int b = 0; b < 4; b++)
                        if (wbe_m[b]) mem_m[widx_m][8*b +: 8] = wdat_m[8*b +: 8];
                    if (wbe_m == 4'hF) mem_v[widx_m] = 1'b1;
                    wr_pend = 1'b0;
                end
                if (cyc >= free_at && doe) begin
                    rd_done_at = cyc + RD_LAT;
                    ridx_m     = daddr[11:2];
                    free_at    = cyc + RD_LAT + 1;
                end else if (cyc >= free_at && dwe) begin
                    busy_from = cyc + 1;
                    busy_to   = cyc + WR_LAT;
                    commit_at = cyc + WR_LAT;
                    wr_pend   = 1'b1;
                    widx_m    = daddr[11:2];
                    wdat_m    = dwdata;
                    wbe_m     = dbe;
                    free_at   = cyc + WR_LAT + 1;
                end
            end
            cyc++;
            exp_rdy_n = (cyc != rd_done_at);
            exp_busy  = (cyc >= busy_from) && (cyc <= busy_to);
            if (cyc == rd_done_at) begin
                exp_rd_ok = mem_v[ridx_m];
                exp_rdata = mem_m[ridx_m];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("dready_n", 32'(dready_n), 32'(exp_rdy_n));
                chk("dbusy", 32'(dbusy), 32'(exp_busy));
                if (exp_rd_ok) chk("drdata", drdata, exp_rdata);
            end
        end
    end

    // Pipeline-style read: hold doe until the completion strobe, then one idle cycle
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int iss, output int done);
        bit ok = 1'b0;
        doe   = 1'b1;
        daddr = a;
        iss   = cyc;
        done  = -1;
        d     = '0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (!dready_n) begin
                ok   = 1'b1;
                d    = drdata;
                done = cyc;
            end
        end
        doe = 1'b0;
        if (!ok) chk("read_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Pipeline-style write: stall while dbusy, posted once dbusy is low
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int acc, output int stall);
        bit ok = 1'b0;
        dwe    = 1'b1;
        daddr  = a;
        dwdata = d;
        dbe    = be;
        stall  = 0;
        acc    = -1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (!dbusy) begin
                ok  = 1'b1;
                acc = cyc;
            end else begin
                stall++;
                @(negedge clk);
            end
        end
        if (!ok) chk("write_timeout", 32'd0, 32'd1);
        @(negedge clk);
        dwe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int iss, done, acc, acc2, st, st2;

        rst    = 1'b0;
        doe    = 1'b1;
        daddr  = 32'h0000_0200;
        dwe    = 1'b0;
        dwdata = 32'd0;
        dbe    = 4'h0;

        // Reset held two edges with a read pending
        repeat (2) @(negedge clk);
        chk("rst_dready_n", 32'(dready_n), 32'd1);
        chk("rst_dbusy", 32'(dbusy), 32'd0);
        chk("rst_drdata", drdata, 32'd0);
        rst = 1'b1;
        do_read(32'h0000_0200, d, iss, done);
        chk("first_read_lat", 32'(done - iss), 32'd2);

        // Full write then read issued the next cycle
        do_write(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, acc, st);
        do_read(32'h0000_0040, d, iss, done);
        chk("wr_rd_lat_from_write", 32'(done - acc), 32'd6);
        chk("wr_rd_data", d, 32'hDEAD_BEEF);

        // Byte-enable merge
        do_write(32'h0000_0080, 32'h1122_3344, 4'hF, acc, st);
        do_write(32'h0000_0080, 32'hAABB_CCDD, 4'b0101, acc, st);
        do_read(32'h0000_0080, d, iss, done);
        chk("byte_merge", d, 32'h11BB_33DD);

        // Back-to-back writes
        do_write(32'h0000_0000, 32'hA5A5_0000, 4'hF, acc, st);
        do_write(32'h0000_0004, 32'h0000_5A5A, 4'hF, acc2, st2);
        chk("b2b_stall", 32'(st2), 32'd3);
        chk("b2b_spacing", 32'(acc2 - acc), 32'd4);
        do_read(32'h0000_0000, d, iss, done);
        chk("b2b_word0", d, 32'hA5A5_0000);
        do_read(32'h0000_0004, d, iss, done);
        chk("b2b_word1", d, 32'h0000_5A5A);

        // Address aliasing above the RAM depth
        do_write(32'h0000_1000, 32'hCAFE_0001, 4'hF, acc, st);
        do_read(32'h0000_0000, d, iss, done);
        chk("alias", d, 32'hCAFE_0001);

        // Reset during the second dbusy cycle loses the buffered write
        do_write(32'h0000_0010, 32'h0BAD_F00D, 4'hF, acc, st);
        do_write(32'h0000_0010, 32'h1234_5678, 4'hF, acc, st);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_drain_dbusy", 32'(dbusy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        do_read(32'h0000_0010, d, iss, done);
        chk("mid_drain_keep", d, 32'h0BAD_F00D);

        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
